// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and helpers for
// the multi-read-port register file.
package regfile_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;
  localparam int NUM_RD    = 2;
  // Widest busy vector popcount accepts.
  localparam int MAX_DEPTH = 256;

  function automatic int unsigned popcount(
    input logic [MAX_DEPTH-1:0] v
  );
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++)
      n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write
// busy bits and registered busy count.
// Ports: clk, rst_n; wr_en/wr_addr release a
// register, resv_en/resv_addr reserve one;
// busy (vector) and busy_cnt (popcount) out.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic                  resv_en,
  input  logic [ADDR_W-1:0]     resv_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0]     r_busy;
  logic [CW-1:0]        r_cnt;
  logic [DEPTH-1:0]     w_nxt;
  logic [MAX_DEPTH-1:0] w_pad;

  // Release first, then reserve: a same-edge
  // reserve of the written register wins.
  always_comb begin
    w_nxt = r_busy;
    if (wr_en)
      w_nxt[wr_addr] = 1'b0;
    if (resv_en)
      w_nxt[resv_addr] = 1'b1;
    if (ZERO_REG != 0)
      w_nxt[0] = 1'b0;
  end

  always_comb begin
    w_pad = '0;
    w_pad[DEPTH-1:0] = w_nxt;
  end

  // Count is taken from the next-state vector
  // so it lands on the same edge as the bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_nxt;
      r_cnt  <= CW'(popcount(w_pad));
    end
  end

  assign busy     = r_busy;
  assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port
// register file with bypass and busy tracking.
// Ports: clk, rst_n; rd_addr/rd_data/rd_busy
// packed per read port; wr_en/wr_addr/wr_data
// writeback; resv_en/resv_addr reserve; busy_cnt.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_RD   = regfile_pkg::NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_busy;
  logic              w_wr;

  assign w_wr = wr_en &&
    !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .busy      (w_busy),
    .busy_cnt  (busy_cnt)
  );

  for (genvar g = 0; g < NUM_RD; g++)
  begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic              w_zero;
    logic              w_hit;

    assign w_a = rd_addr[g*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) &&
                    (w_a == '0);
    assign w_hit = wr_en && (wr_addr == w_a);

    assign rd_data[g*DATA_W +: DATA_W] =
      w_zero ? '0 :
      w_hit  ? wr_data :
               r_mem[w_a];

    // A same-cycle write satisfies the reader.
    assign rd_busy[g] =
      !w_zero && w_busy[w_a] && !w_hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp,
// default build plus a 16b/8x/4-port/no-zero build.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_resv_en;
  logic [4:0]  a_resv_addr;
  logic [5:0]  a_cnt;

  logic [11:0] b_rd_addr;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_busy;
  logic        b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_resv_en;
  logic [2:0]  b_resv_addr;
  logic [3:0]  b_cnt;

  regfile_mp u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (a_rd_addr),
    .rd_data   (a_rd_data),
    .rd_busy   (a_rd_busy),
    .wr_en     (a_wr_en),
    .wr_addr   (a_wr_addr),
    .wr_data   (a_wr_data),
    .resv_en   (a_resv_en),
    .resv_addr (a_resv_addr),
    .busy_cnt  (a_cnt)
  );

  regfile_mp #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .NUM_RD   (4),
    .ZERO_REG (0)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (b_rd_addr),
    .rd_data   (b_rd_data),
    .rd_busy   (b_rd_busy),
    .wr_en     (b_wr_en),
    .wr_addr   (b_wr_addr),
    .wr_data   (b_wr_data),
    .resv_en   (b_resv_en),
    .resv_addr (b_resv_addr),
    .busy_cnt  (b_cnt)
  );

  typedef struct {
    string       nm;
    bit          b;
    logic [63:0] d;
    logic [3:0]  bz;
    logic [5:0]  c;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  // Monitor: checks every queued expectation
  // on the falling edge after it was issued.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] ad;
      logic [3:0]  ab;
      logic [5:0]  ac;
      e = q.pop_front();
      if (e.b) begin
        ad = b_rd_data;
        ab = b_rd_busy;
        ac = {2'b00, b_cnt};
      end else begin
        ad = a_rd_data;
        ab = {2'b00, a_rd_busy};
        ac = a_cnt;
      end
      n_run++;
      if (ad !== e.d || ab !== e.bz ||
          ac !== e.c) begin
        n_fail++;
        $display(
          "FAIL %s: got d=%h bz=%b c=%0d want d=%h bz=%b c=%0d",
          e.nm, ad, ab, ac, e.d, e.bz, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_in(
    input bit          we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input bit          re,
    input logic [4:0]  ra,
    input logic [4:0]  p1,
    input logic [4:0]  p0
  );
    a_wr_en     = we;
    a_wr_addr   = wa;
    a_wr_data   = wd;
    a_resv_en   = re;
    a_resv_addr = ra;
    a_rd_addr   = {p1, p0};
  endtask

  task automatic b_in(
    input bit          we,
    input logic [2:0]  wa,
    input logic [15:0] wd,
    input bit          re,
    input logic [2:0]  ra,
    input logic [11:0] ports
  );
    b_wr_en     = we;
    b_wr_addr   = wa;
    b_wr_data   = wd;
    b_resv_en   = re;
    b_resv_addr = ra;
    b_rd_addr   = ports;
  endtask

  task automatic exp_a(
    input string       nm,
    input logic [31:0] d1,
    input logic [31:0] d0,
    input logic [1:0]  bz,
    input logic [5:0]  c
  );
    exp_t e;
    e.nm = nm;
    e.b  = 1'b0;
    e.d  = {d1, d0};
    e.bz = {2'b00, bz};
    e.c  = c;
    q.push_back(e);
  endtask

  task automatic exp_b(
    input string       nm,
    input logic [63:0] d,
    input logic [3:0]  bz,
    input logic [3:0]  c
  );
    exp_t e;
    e.nm = nm;
    e.b  = 1'b1;
    e.d  = d;
    e.bz = bz;
    e.c  = {2'b00, c};
    q.push_back(e);
  endtask

  localparam logic [31:0] V3 = 32'hABCDEF12;
  localparam logic [31:0] V5 = 32'h12345678;

  initial begin
    a_in(0, 0, 0, 0, 0, 0, 0);
    b_in(0, 0, 0, 0, 0, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_in(0, 0, 0, 0, 0, 0, 3);
    exp_a("reset", 0, 0, 2'b00, 0);

    step(); a_in(1, 3, V3, 0, 0, 3, 3);
    exp_a("wr_bypass", V3, V3, 2'b00, 0);
    step(); a_in(0, 0, 0, 0, 0, 3, 3);
    exp_a("wr_array", V3, V3, 2'b00, 0);
    step();
    exp_a("wr_hold", V3, V3, 2'b00, 0);

    step(); a_in(1, 0, 32'hFFFFFFFF, 0, 0, 3, 0);
    exp_a("r0_wr_cycle", V3, 0, 2'b00, 0);
    step(); a_in(0, 0, 0, 0, 0, 3, 0);
    exp_a("r0_zero", V3, 0, 2'b00, 0);

    step(); a_in(0, 0, 0, 1, 5, 3, 5);
    exp_a("resv_cycle", V3, 0, 2'b00, 0);
    step(); a_in(0, 0, 0, 0, 0, 3, 5);
    exp_a("resv_busy", V3, 0, 2'b01, 1);
    step(); a_in(1, 5, V5, 0, 0, 3, 5);
    exp_a("release_byp", V3, V5, 2'b00, 1);
    step(); a_in(0, 0, 0, 0, 0, 3, 5);
    exp_a("release_done", V3, V5, 2'b00, 0);

    step(); a_in(1, 7, 32'h77, 1, 7, 8, 7);
    exp_a("same_cycle", 0, 32'h77, 2'b00, 0);
    step(); a_in(0, 0, 0, 0, 0, 8, 7);
    exp_a("same_busy", 0, 32'h77, 2'b01, 1);

    step(); a_in(1, 9, 32'h99, 1, 8, 9, 8);
    exp_a("diff_cycle", 32'h99, 0, 2'b00, 1);
    step(); a_in(0, 0, 0, 0, 0, 9, 8);
    exp_a("diff_busy", 32'h99, 0, 2'b01, 2);

    step(); a_in(1, 7, 32'h70, 0, 0, 8, 7);
    exp_a("clr_r7", 0, 32'h70, 2'b10, 2);
    step(); a_in(1, 8, 32'h80, 0, 0, 8, 7);
    exp_a("clr_r8", 32'h80, 32'h70, 2'b00, 1);
    step(); a_in(0, 0, 0, 0, 0, 8, 7);
    exp_a("clr_done", 32'h80, 32'h70, 2'b00, 0);

    step(); a_in(0, 0, 0, 1, 4, 3, 4);
    step(); a_in(0, 0, 0, 1, 4, 3, 4);
    exp_a("rersv_cycle", V3, 0, 2'b01, 1);
    step(); a_in(1, 4, 32'h44, 0, 0, 3, 4);
    exp_a("rersv_rel", V3, 32'h44, 2'b00, 1);
    step(); a_in(0, 0, 0, 0, 0, 3, 4);
    exp_a("rersv_done", V3, 32'h44, 2'b00, 0);

    step(); a_in(0, 0, 0, 1, 0, 3, 0);
    step(); a_in(0, 0, 0, 0, 0, 3, 0);
    exp_a("r0_resv_noop", V3, 0, 2'b00, 0);

    step(); a_in(0, 0, 0, 1, 5, 3, 5);
    step(); a_in(0, 0, 0, 0, 0, 3, 5);
    exp_a("pre_reset", V3, V5, 2'b01, 1);
    step(); rst_n = 1'b0;
    exp_a("async_reset", 0, 0, 2'b00, 0);
    step();
    exp_a("reset_hold", 0, 0, 2'b00, 0);
    step(); rst_n = 1'b1;
    a_in(1, 3, 32'h33, 0, 0, 3, 5);
    exp_a("first_cycle", 32'h33, 0, 2'b00, 0);
    step(); a_in(0, 0, 0, 0, 0, 3, 5);
    exp_a("first_edge", 32'h33, 0, 2'b00, 0);

    step(); b_in(1, 0, 16'h00AA, 0, 0, 12'o0000);
    exp_b("b_r0_bypass", {4{16'h00AA}},
          4'b0000, 0);
    step(); b_in(0, 0, 0, 0, 0, 12'o0000);
    exp_b("b_r0_array", {4{16'h00AA}},
          4'b0000, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      b_in(0, 0, 0, 1, 3'(i), 12'o0000);
    end
    step(); b_in(0, 0, 0, 0, 0, 12'o3210);
    exp_b("b_all_busy", 64'h00AA,
          4'b1111, 8);
    step(); b_in(1, 5, 16'h5555, 0, 0, 12'o0765);
    exp_b("b_mixed",
          64'h00AA_0000_0000_5555, 4'b1110, 8);
    step(); b_in(0, 0, 0, 0, 0, 12'o0765);
    exp_b("b_after_wr",
          64'h00AA_0000_0000_5555, 4'b1110, 7);

    step();
    step();
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, want 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
